// File: rtl/uart_rx.sv
// Oversampled UART receiver: 2-of-3 mid-bit majority vote, optional parity,
// break detection, and a single-entry valid/ready output register with overrun pulse.
module uart_rx #(
  parameter int OSR    = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic              osr_tick_i,
  input  logic              rx_i,
  input  logic              parity_en_i,
  input  logic              parity_odd_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              frame_err_o,
  output logic              parity_err_o,
  output logic              overrun_o,
  output logic              busy_o
);

  localparam int TW = $clog2(OSR);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TW-1:0] T_S0  = TW'(OSR/2 - 2);
  localparam logic [TW-1:0] T_S1  = TW'(OSR/2 - 1);
  localparam logic [TW-1:0] T_DEC = TW'(OSR/2);
  localparam logic [TW-1:0] T_END = TW'(OSR - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t              state_q, state_d;
  logic [1:0]          sync_q;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [1:0]          samp_q, samp_d;
  logic [BW-1:0]       bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_en_q, par_en_d;
  logic                par_odd_q, par_odd_d;
  logic                perr_q, perr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                vld_q, vld_d;
  logic                ferr_q, ferr_d;
  logic                perr_out_q, perr_out_d;
  logic                ovr_q, ovr_d;

  logic rxs, tick, maj, dec, bit_end, done;

  assign rxs     = sync_q[1];
  assign tick    = osr_tick_i & en_i;
  assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
  assign dec     = tick && (tcnt_q == T_DEC);
  assign bit_end = tick && (tcnt_q == T_END);

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = IDLE;
    end else if (tick) begin
      case (state_q)
        IDLE:    if (!rxs) state_d = START;
        START:   if (dec && maj) state_d = IDLE;
                 else if (bit_end) state_d = DATA;
        DATA:    if (bit_end && bitcnt_q == B_LAST) state_d = par_en_q ? PARITY : STOP;
        PARITY:  if (bit_end) state_d = STOP;
        STOP:    if (dec) state_d = maj ? IDLE : BREAK;
        BREAK:   if (rxs) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    busy_o = (state_q != IDLE);
    done   = (state_q == STOP) && dec;
  end

  // Bit timing, sampling and data assembly
  always_comb begin
    tcnt_d    = tcnt_q;
    samp_d    = samp_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    perr_d    = perr_q;
    if (!en_i) begin
      tcnt_d   = '0;
      bitcnt_d = '0;
      shift_d  = '0;
    end else if (tick) begin
      if (state_q == IDLE)
        tcnt_d = rxs ? '0 : TW'(1);
      else if (tcnt_q == T_END || state_d == IDLE || state_d == BREAK)
        tcnt_d = '0;
      else
        tcnt_d = tcnt_q + 1'b1;

      if (tcnt_q == T_S0) samp_d[0] = rxs;
      if (tcnt_q == T_S1) samp_d[1] = rxs;

      case (state_q)
        START: if (bit_end) begin
          bitcnt_d  = '0;
          par_en_d  = parity_en_i;
          par_odd_d = parity_odd_i;
          perr_d    = 1'b0;
        end
        DATA: begin
          if (dec) shift_d = {maj, shift_q[DATA_W-1:1]};
          if (bit_end && bitcnt_q != B_LAST) bitcnt_d = bitcnt_q + 1'b1;
        end
        PARITY: if (dec) perr_d = maj ^ (^shift_q) ^ par_odd_q;
        default: ;
      endcase
    end
  end

  // Output holding register and handshake
  always_comb begin
    data_d     = data_q;
    vld_d      = vld_q;
    ferr_d     = ferr_q;
    perr_out_d = perr_out_q;
    ovr_d      = 1'b0;
    if (done) begin
      if (!vld_q || rx_ready_i) begin
        data_d     = shift_q;
        ferr_d     = ~maj;
        perr_out_d = perr_q & par_en_q;
        vld_d      = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (vld_q && rx_ready_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q     <= 2'b11;
      tcnt_q     <= '0;
      samp_q     <= 2'b11;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      vld_q      <= 1'b0;
      ferr_q     <= 1'b0;
      perr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx_i};
      tcnt_q     <= tcnt_d;
      samp_q     <= samp_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      vld_q      <= vld_d;
      ferr_q     <= ferr_d;
      perr_out_q <= perr_out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data_o    = data_q;
  assign rx_valid_o   = vld_q;
  assign frame_err_o  = ferr_q;
  assign parity_err_o = perr_out_q;
  assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at OSR=16 with a tick every clock; one bit = 16 cycles.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int OSR = 16;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1, en_i = 1'b1, osr_tick_i = 1'b1, rx_i = 1'b1;
  logic       parity_en_i = 1'b0, parity_odd_i = 1'b0, rx_ready_i = 1'b1;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, frame_err_o, parity_err_o, overrun_o, busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int vld_cnt  = 0;
  int ovr_cnt  = 0;
  logic [7:0] cap_data;
  logic       cap_ferr, cap_perr;

  uart_rx #(.OSR(OSR), .DATA_W(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .osr_tick_i(osr_tick_i),
    .rx_i(rx_i), .parity_en_i(parity_en_i), .parity_odd_i(parity_odd_i),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .frame_err_o(frame_err_o), .parity_err_o(parity_err_o),
    .overrun_o(overrun_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Record every valid cycle and overrun pulse, latching the delivered frame.
  always @(negedge clk_i) begin
    if (rx_valid_o === 1'b1) begin
      vld_cnt++;
      cap_data = rx_data_o;
      cap_ferr = frame_err_o;
      cap_perr = parity_err_o;
    end
    if (overrun_o === 1'b1) ovr_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    cyc(OSR);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit, input logic stopb);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(stopb);
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    rx_i = 1'b1;
    cyc(3);
    n_checks++; if (rx_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rx_data_o); end
    n_checks++; if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rx_valid_o); end
    n_checks++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frame_err_o); end
    n_checks++; if (parity_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", parity_err_o); end
    n_checks++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", overrun_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    reset_i = 1'b0;
    cyc(4);
  endtask

  task automatic test_basic;
    int v0;
    v0 = vld_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    n_checks++; if (vld_cnt - v0 != 1) begin n_fail++; $display("FAIL basic_valid_cycles: got %0d want 1", vld_cnt - v0); end
    n_checks++; if (cap_data !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h want a5", cap_data); end
    n_checks++; if (cap_ferr !== 1'b0) begin n_fail++; $display("FAIL basic_ferr: got %b want 0", cap_ferr); end
    n_checks++; if (cap_perr !== 1'b0) begin n_fail++; $display("FAIL basic_perr: got %b want 0", cap_perr); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b want 0", busy_o); end
    cyc(4);
  endtask

  task automatic test_parity;
    int v0;
    parity_en_i  = 1'b1;
    parity_odd_i = 1'b1;
    v0 = vld_cnt;
    send_frame(8'h03, 1'b1, 1'b0, 1'b1);
    n_checks++; if (vld_cnt - v0 != 1) begin n_fail++; $display("FAIL par_bad_valid: got %0d want 1", vld_cnt - v0); end
    n_checks++; if (cap_data !== 8'h03) begin n_fail++; $display("FAIL par_bad_data: got %h want 03", cap_data); end
    n_checks++; if (cap_perr !== 1'b1) begin n_fail++; $display("FAIL par_bad_perr: got %b want 1", cap_perr); end
    n_checks++; if (cap_ferr !== 1'b0) begin n_fail++; $display("FAIL par_bad_ferr: got %b want 0", cap_ferr); end
    v0 = vld_cnt;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    n_checks++; if (vld_cnt - v0 != 1) begin n_fail++; $display("FAIL par_ok_valid: got %0d want 1", vld_cnt - v0); end
    n_checks++; if (cap_perr !== 1'b0) begin n_fail++; $display("FAIL par_ok_perr: got %b want 0", cap_perr); end
    parity_en_i  = 1'b0;
    parity_odd_i = 1'b0;
    cyc(4);
  endtask

  task automatic test_false_start;
    int v0;
    v0 = vld_cnt;
    rx_i = 1'b0;
    cyc(5);
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL fs_busy_high: got %b want 1", busy_o); end
    rx_i = 1'b1;
    cyc(16);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL fs_busy_low: got %b want 0", busy_o); end
    n_checks++; if (vld_cnt - v0 != 0) begin n_fail++; $display("FAIL fs_no_output: got %0d want 0", vld_cnt - v0); end
  endtask

  task automatic test_break;
    int v0;
    v0 = vld_cnt;
    send_frame(8'h00, 1'b0, 1'b0, 1'b0);
    cyc(40);
    n_checks++; if (vld_cnt - v0 != 1) begin n_fail++; $display("FAIL brk_valid_cycles: got %0d want 1", vld_cnt - v0); end
    n_checks++; if (cap_data !== 8'h00) begin n_fail++; $display("FAIL brk_data: got %h want 00", cap_data); end
    n_checks++; if (cap_ferr !== 1'b1) begin n_fail++; $display("FAIL brk_ferr: got %b want 1", cap_ferr); end
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL brk_busy_held: got %b want 1", busy_o); end
    rx_i = 1'b1;
    cyc(20);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL brk_busy_release: got %b want 0", busy_o); end
    v0 = vld_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    n_checks++; if (vld_cnt - v0 != 1) begin n_fail++; $display("FAIL brk_next_valid: got %0d want 1", vld_cnt - v0); end
    n_checks++; if (cap_data !== 8'h55) begin n_fail++; $display("FAIL brk_next_data: got %h want 55", cap_data); end
    n_checks++; if (cap_ferr !== 1'b0) begin n_fail++; $display("FAIL brk_next_ferr: got %b want 0", cap_ferr); end
    cyc(4);
  endtask

  task automatic test_back_to_back;
    int o0;
    rx_ready_i = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    n_checks++; if (ovr_cnt - o0 != 0) begin n_fail++; $display("FAIL b2b_first_ovr: got %0d want 0", ovr_cnt - o0); end
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    n_checks++; if (rx_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_held: got %b want 1", rx_valid_o); end
    n_checks++; if (rx_data_o !== 8'h11) begin n_fail++; $display("FAIL b2b_data_kept: got %h want 11", rx_data_o); end
    n_checks++; if (ovr_cnt - o0 != 1) begin n_fail++; $display("FAIL b2b_ovr_pulses: got %0d want 1", ovr_cnt - o0); end
    rx_ready_i = 1'b1;
    cyc(1);
    n_checks++; if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_handshake: got %b want 0", rx_valid_o); end
    n_checks++; if (rx_data_o !== 8'h11) begin n_fail++; $display("FAIL b2b_data_after_hs: got %h want 11", rx_data_o); end
    cyc(4);
  endtask

  task automatic test_reset_mid;
    int v0;
    logic [7:0] d;
    d = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rx_i = d[3];
    cyc(OSR/2);
    reset_i = 1'b1;
    cyc(1);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy_o); end
    n_checks++; if (rx_data_o !== 8'h00) begin n_fail++; $display("FAIL rmid_data: got %h want 00", rx_data_o); end
    n_checks++; if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", rx_valid_o); end
    n_checks++; if (frame_err_o !== 1'b0 || parity_err_o !== 1'b0 || overrun_o !== 1'b0) begin
      n_fail++; $display("FAIL rmid_flags: got f%b p%b o%b want 000", frame_err_o, parity_err_o, overrun_o);
    end
    reset_i = 1'b0;
    rx_i = 1'b1;
    cyc(20);
    v0 = vld_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    n_checks++; if (vld_cnt - v0 != 1) begin n_fail++; $display("FAIL rmid_next_valid: got %0d want 1", vld_cnt - v0); end
    n_checks++; if (cap_data !== 8'h3C) begin n_fail++; $display("FAIL rmid_next_data: got %h want 3c", cap_data); end
    n_checks++; if (cap_ferr !== 1'b0) begin n_fail++; $display("FAIL rmid_next_ferr: got %b want 0", cap_ferr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_false_start();
    test_break();
    test_back_to_back();
    test_reset_mid();
    cyc(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OSR, default 16, oversampling ticks per bit; even, >= 8.
REQ-002 SHALL have parameter DATA_W, default 8, data bits per frame.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en_i  input  1  receiver enable.
REQ-006 SHALL have port osr_tick_i  input  1  one-cycle oversampling tick from the baud generator.
REQ-007 SHALL have port rx_i  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port parity_en_i  input  1  parity bit present after the data bits.
REQ-009 SHALL have port parity_odd_i  input  1  1 = odd parity, 0 = even parity.
REQ-010 SHALL have port rx_data_o  output  DATA_W  received data, LSB first on the line.
REQ-011 SHALL have port rx_valid_o  output  1  rx_data_o and error flags hold a frame.
REQ-012 SHALL have port rx_ready_i  input  1  consumer accepts the frame when rx_valid_o=1.
REQ-013 SHALL have port frame_err_o  output  1  stop bit sampled low; qualified by rx_valid_o.
REQ-014 SHALL have port parity_err_o  output  1  parity mismatch; qualified by rx_valid_o.
REQ-015 SHALL have port overrun_o  output  1  one-cycle pulse when a completed frame is dropped.
REQ-016 SHALL have port busy_o  output  1  state != IDLE.

Function
REQ-017 SHALL pass rx_i through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value rxs.
REQ-018 SHALL advance the sampling FSM and tick counter tcnt (0..OSR-1) only on cycles where osr_tick_i=1.
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-020 IDLE: on tick with rxs=0 -> START, tcnt<=1; otherwise stay.
REQ-021 SHALL take samples on ticks where tcnt = OSR/2-2, OSR/2-1, OSR/2 and decide each bit by 2-of-3 majority on the tick where tcnt = OSR/2.
REQ-022 START: if majority = 1 at decision -> IDLE (false start, no output); else continue; on tick with tcnt=OSR-1 -> DATA, tcnt<=0.
REQ-023 DATA: shift decided bit into the data shift register LSB first; after DATA_W bits, on tcnt=OSR-1 -> PARITY if parity_en_i else STOP; tcnt wraps to 0 at each bit end.
REQ-024 PARITY: expected bit = XOR(data) XOR parity_odd_i; mismatch sets the internal parity error; on tcnt=OSR-1 -> STOP.
REQ-025 STOP: at the decision tick (mid-bit) complete the frame: majority 1 -> IDLE; majority 0 -> BREAK with frame error set.
REQ-026 BREAK: stay until a tick with rxs=1, then -> IDLE; start detection is suppressed in BREAK.
REQ-027 Frame completion, rx_valid_o=0 or (rx_valid_o=1 and rx_ready_i=1) the same cycle: load rx_data_o, frame_err_o, parity_err_o; rx_valid_o<=1.
REQ-028 Frame completion, rx_valid_o=1 and rx_ready_i=0: drop the new frame, keep the held frame, pulse overrun_o for exactly 1 cycle.
REQ-029 Handshake: rx_valid_o=1 and rx_ready_i=1 with no completion that cycle -> rx_valid_o<=0; rx_data_o holds its last value.
REQ-030 parity_err_o SHALL be 0 for frames received with parity_en_i=0.
REQ-031 parity_en_i and parity_odd_i SHALL be sampled at the START->DATA transition and held for the frame.
REQ-032 en_i=0: FSM -> IDLE, tcnt<=0, shift register cleared on the next clock; the output register, rx_valid_o, and handshake are unaffected.
REQ-033 osr_tick_i asserted while en_i=0 SHALL be ignored.

Reset
REQ-034 reset_i=1 SHALL force: state IDLE, tcnt=0, synchronizer flops=1, rx_data_o=0, rx_valid_o=0, frame_err_o=0, parity_err_o=0, overrun_o=0, busy_o=0.
REQ-035 reset_i mid-frame SHALL abort the frame without producing output; reset has priority over all other inputs.

Verification
REQ-036 OSR=16, tick every cycle, no parity, rx_ready_i=1: frame 0xA5 -> rx_valid_o=1 for one cycle, rx_data_o=0xA5, both error flags 0.
REQ-037 Parity enabled and odd: send 0x03 with parity bit 0 -> parity_err_o=1; same data with parity bit 1 -> parity_err_o=0.
REQ-038 rx_i low for 5 ticks then high -> no output, busy_o returns to 0 within 16 ticks.
REQ-039 Send 0x00 with stop bit low, line then held low 40 ticks -> frame_err_o=1, rx_data_o=0x00; no new frame while low; after line high, next frame 0x55 is received correctly.
REQ-040 rx_ready_i=0, two back-to-back frames 0x11, 0x22 -> rx_data_o=0x11 retained, overrun_o pulses once at second completion.
REQ-041 reset_i asserted at DATA bit 3 -> all outputs at reset values next cycle; subsequent frame 0x3C received correctly.
